sram16_ctrl: RTL and testbench

Synchronous initiator for an external asynchronous 32Kx8 SRAM. It accepts 16-bit word read/write requests from the xr16 memory bus side, splits each word into two big-endian byte accesses, and drives the SRAM control, address and data pins with registered, glitch-free strobes. It sits between the on-chip bus and the board-level SRAM; the top level builds the bidirectional data bus as `dq = sram_dq_oe ? sram_dq_o : 8'bz`.

---
 rtl/sram16_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram16_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram16_ctrl.sv
`timescale 1ns/1ps
// sram16_ctrl
// Synchronous initiator for an external asynchronous 32Kx8 SRAM. A 16-bit
// word request from the xr16 bus is split into up to two big-endian byte
// accesses (even byte = word[15:8] first, odd byte = word[7:0] second). Each
// byte access is SETUP (1 clk), STROBE (WAIT+1 clks), HOLD (1 clk). Every SRAM
// pin is driven straight from a flop.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   req_valid/req_ready   request handshake, ready only while idle
//   req_we                1 = write, 0 = read
//   req_addr[13:0]        word address
//   req_wdata[15:8]       even-byte write data, [7:0] odd-byte write data
//   req_be[1:0]           write byte enables, [1] even, [0] odd
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata[15:0]       read data, held until the next read completes
//   sram_ce_n/we_n/oe_n   active-low SRAM strobes
//   sram_addr[14:0]       SRAM byte address
//   sram_dq_o/sram_dq_oe  pin write data and driver enable
//   sram_dq_i             pin read data
module sram16_ctrl #(
   parameter int WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [13:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_be,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        sram_ce_n,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic [14:0] sram_addr,
   output logic [7:0]  sram_dq_o,
   output logic        sram_dq_oe,
   input  logic [7:0]  sram_dq_i
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic        byte_sel;      // 0 = even (high) byte, 1 = odd (low) byte
   logic        we_q;
   logic [13:0] addr_q;
   logic [15:0] wdata_q;
   logic [1:0]  be_q;
   logic [7:0]  rd_hi;         // even byte of a read, parked until the word completes
   logic        accept;
   logic        first_odd;
   logic        last_byte;

   // Gating with rst_n keeps ready low for the whole reset window, even
   // though the state register already reads IDLE after the first reset edge.
   assign req_ready = rst_n & (state == IDLE);
   assign accept    = req_valid & req_ready;

   // A write that does not enable the even byte starts directly on the odd one.
   assign first_odd = req_we & ~req_be[1];

   // The current byte is the last one when it is the odd byte, or when it is
   // the even byte of a write whose odd byte is disabled.
   assign last_byte = byte_sel | (we_q & ~be_q[0]);

   // Request capture and read-byte parking carry no reset: they are always
   // written before they are used.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
      if (state == STROBE && cnt == 3'd0 && !byte_sel) begin
         rd_hi <= sram_dq_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         byte_sel   <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_addr  <= 15'd0;
         sram_dq_o  <= 8'd0;
         sram_dq_oe <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 16'd0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (req_we && req_be == 2'b00) begin
                     // Nothing to transfer: complete without touching the pins.
                     rsp_valid <= 1'b1;
                  end else begin
                     state      <= SETUP;
                     byte_sel   <= first_odd;
                     sram_ce_n  <= 1'b0;
                     sram_addr  <= {req_addr, first_odd};
                     sram_dq_oe <= req_we;
                     sram_dq_o  <= first_odd ? req_wdata[7:0] : req_wdata[15:8];
                  end
               end
            end
            SETUP: begin
               state     <= STROBE;
               cnt       <= 3'(WAIT);
               sram_we_n <= ~we_q;
               sram_oe_n <= we_q;
            end
            STROBE: begin
               if (cnt == 3'd0) begin
                  state     <= HOLD;
                  sram_we_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  if (!we_q && byte_sel) begin
                     rsp_rdata <= {rd_hi, sram_dq_i};
                  end
                  if (last_byte) begin
                     rsp_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            HOLD: begin
               if (!last_byte) begin
                  state     <= SETUP;
                  byte_sel  <= 1'b1;
                  sram_addr <= {addr_q, 1'b1};
                  sram_dq_o <= wdata_q[7:0];
               end else begin
                  state      <= IDLE;
                  sram_ce_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram16_ctrl.sv
`timescale 1ns/1ps
// Testbench for sram16_ctrl: one instance with WAIT=1 and one with WAIT=0,
// each attached to its own behavioural 32Kx8 SRAM.
module tb_sram16_ctrl;

   typedef struct {
      bit          is_rd;
      logic [15:0] rdata;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [13:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        inst;            // 1 selects the WAIT=1 instance, 0 the WAIT=0 one

   logic        r1_valid, r1_ready, r1_rsp_valid, r1_ce_n, r1_we_n, r1_oe_n, r1_dq_oe;
   logic [15:0] r1_rdata;
   logic [14:0] r1_addr;
   logic [7:0]  r1_dq_o, r1_dq_i;
   logic        r0_valid, r0_ready, r0_rsp_valid, r0_ce_n, r0_we_n, r0_oe_n, r0_dq_oe;
   logic [15:0] r0_rdata;
   logic [14:0] r0_addr;
   logic [7:0]  r0_dq_o, r0_dq_i;

   logic        m_ready, m_rsp_valid, m_ce_n, m_we_n, m_oe_n, m_dq_oe;
   logic [15:0] m_rdata;
   logic [14:0] m_addr;

   logic [7:0]  mem1 [0:32767];
   logic [7:0]  mem0 [0:32767];

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   int   bad_inv = 0;
   int   rdy_bad = 0;
   int   ce_act = 0;
   int   oe_dq = 0;
   int   we_run = 0;
   int   we_runs[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign r1_valid = req_valid & inst;
   assign r0_valid = req_valid & ~inst;

   sram16_ctrl #(.WAIT(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rdata),
      .sram_ce_n(r1_ce_n), .sram_we_n(r1_we_n), .sram_oe_n(r1_oe_n),
      .sram_addr(r1_addr), .sram_dq_o(r1_dq_o), .sram_dq_oe(r1_dq_oe), .sram_dq_i(r1_dq_i)
   );

   sram16_ctrl #(.WAIT(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .req_valid(r0_valid), .req_ready(r0_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rdata),
      .sram_ce_n(r0_ce_n), .sram_we_n(r0_we_n), .sram_oe_n(r0_oe_n),
      .sram_addr(r0_addr), .sram_dq_o(r0_dq_o), .sram_dq_oe(r0_dq_oe), .sram_dq_i(r0_dq_i)
   );

   // Behavioural SRAMs: reads are combinational while ce_n and oe_n are low,
   // writes land while ce_n and we_n are low with the driver enabled.
   assign r1_dq_i = (!r1_ce_n && !r1_oe_n) ? mem1[r1_addr] : 8'h00;
   assign r0_dq_i = (!r0_ce_n && !r0_oe_n) ? mem0[r0_addr] : 8'h00;

   always @(posedge clk) begin
      if (!r1_ce_n && !r1_we_n && r1_dq_oe) mem1[r1_addr] <= r1_dq_o;
      if (!r0_ce_n && !r0_we_n && r0_dq_oe) mem0[r0_addr] <= r0_dq_o;
   end

   assign m_ready     = inst ? r1_ready     : r0_ready;
   assign m_rsp_valid = inst ? r1_rsp_valid : r0_rsp_valid;
   assign m_ce_n      = inst ? r1_ce_n      : r0_ce_n;
   assign m_we_n      = inst ? r1_we_n      : r0_we_n;
   assign m_oe_n      = inst ? r1_oe_n      : r0_oe_n;
   assign m_dq_oe     = inst ? r1_dq_oe     : r0_dq_oe;
   assign m_rdata     = inst ? r1_rdata     : r0_rdata;
   assign m_addr      = inst ? r1_addr      : r0_addr;

   // Pin monitor on the selected instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         we_run = 0;
      end else begin
         if (!m_we_n && !m_oe_n) bad_inv++;
         if (m_dq_oe && !m_oe_n) bad_inv++;
         if (m_ready && !m_ce_n) rdy_bad++;
         if (!m_ce_n) ce_act++;
         if (m_dq_oe) oe_dq++;
         if (!m_we_n) we_run++;
         else if (we_run != 0) begin
            we_runs.push_back(we_run);
            we_run = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Issues one request starting at a negedge and waits for its completion.
   // Returns got=0 when either the handshake or the response never arrives.
   task automatic run_txn(input logic we, input logic [13:0] a, input logic [15:0] d,
                          input logic [1:0] be, output logic got,
                          output logic [15:0] rd, output int lat);
      int acc;
      logic seen;
      got = 1'b0; rd = 16'h0; lat = 0; acc = -1000; seen = 1'b0;
      req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (m_ready) begin
            acc = cyc + 1;
            seen = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (m_rsp_valid) begin
            got = seen;
            rd  = m_rdata;
            lat = cyc - acc + 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic got;
      logic [15:0] rd;
      int lat;
      inst = 1'b1;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = 14'h0; req_wdata = 16'h0; req_be = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({r1_ce_n, r1_we_n, r1_oe_n, r1_dq_oe, r1_rsp_valid} !== 5'b11100)
         $display("FAIL reset_strobes: ce/we/oe/oe_dq/rsp = %b, want 11100",
                  {r1_ce_n, r1_we_n, r1_oe_n, r1_dq_oe, r1_rsp_valid});
      else n_pass++;
      n_total++;
      if ({r1_addr, r1_dq_o, r1_rdata} !== 39'd0)
         $display("FAIL reset_data: addr=%h dq_o=%h rdata=%h, want all 0", r1_addr, r1_dq_o, r1_rdata);
      else n_pass++;
      n_total++;
      if ({r1_ready, r0_ready} !== 2'b00)
         $display("FAIL reset_ready_low: ready(w1,w0)=%b, want 00", {r1_ready, r0_ready});
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++;
      if (r1_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, want 1", r1_ready);
      else n_pass++;

      // Start a word write and pull reset in its first strobe cycle.
      @(negedge clk);
      req_we = 1'b1; req_addr = 14'h0100; req_wdata = 16'h1122; req_be = 2'b11; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (r1_we_n !== 1'b0) $display("FAIL reset_pre_strobe: we_n=%b, want 0", r1_we_n);
      else n_pass++;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({r1_ce_n, r1_we_n, r1_oe_n, r1_dq_oe, r1_rsp_valid} !== 5'b11100)
            $display("FAIL reset_mid_strobe_%0d: ce/we/oe/oe_dq/rsp = %b, want 11100", i,
                     {r1_ce_n, r1_we_n, r1_oe_n, r1_dq_oe, r1_rsp_valid});
         else n_pass++;
      end
      rst_n = 1'b1;
      #1;
      n_total++;
      if (r1_ready !== 1'b1) $display("FAIL reset_rerelease_ready: got %b, want 1", r1_ready);
      else n_pass++;
      @(negedge clk);
      sb.push_back('{is_rd: 1'b0, rdata: 16'h0, lat: 8});
      run_txn(1'b1, 14'h0100, 16'hC3D4, 2'b11, got, rd, lat);
      begin
         exp_t e;
         e = sb.pop_front();
         n_total++;
         if (got !== 1'b1) $display("FAIL reset_after_rsp: rsp seen=%b, want 1", got);
         else n_pass++;
         n_total++;
         if (lat !== e.lat) $display("FAIL reset_after_lat: got %0d, want %0d", lat, e.lat);
         else n_pass++;
      end
      n_total++;
      if ({mem1[15'h0200], mem1[15'h0201]} !== 16'hC3D4)
         $display("FAIL reset_after_mem: got %h, want c3d4", {mem1[15'h0200], mem1[15'h0201]});
      else n_pass++;
   endtask

   task automatic test_word_write;
      logic got;
      logic [15:0] rd;
      int lat, b_run, b_inv;
      exp_t e;
      inst = 1'b1;
      b_run = we_runs.size(); b_inv = bad_inv;
      sb.push_back('{is_rd: 1'b0, rdata: 16'h0, lat: 8});
      run_txn(1'b1, 14'h0005, 16'hA55A, 2'b11, got, rd, lat);
      e = sb.pop_front();
      n_total++;
      if (got !== 1'b1) $display("FAIL word_write_rsp: rsp seen=%b, want 1", got);
      else n_pass++;
      n_total++;
      if (lat !== e.lat) $display("FAIL word_write_lat: got %0d, want %0d", lat, e.lat);
      else n_pass++;
      n_total++;
      if ({mem1[15'h000A], mem1[15'h000B]} !== 16'hA55A)
         $display("FAIL word_write_mem: got %h, want a55a", {mem1[15'h000A], mem1[15'h000B]});
      else n_pass++;
      n_total++;
      if (we_runs.size() - b_run !== 2)
         $display("FAIL word_write_strobe_count: got %0d, want 2", we_runs.size() - b_run);
      else n_pass++;
      for (int k = b_run; k < we_runs.size(); k++) begin
         n_total++;
         if (we_runs[k] !== 2) $display("FAIL word_write_strobe_width: got %0d, want 2", we_runs[k]);
         else n_pass++;
      end
      n_total++;
      if (bad_inv - b_inv !== 0) $display("FAIL word_write_invariant: got %0d, want 0", bad_inv - b_inv);
      else n_pass++;
   endtask

   task automatic test_readback;
      logic got;
      logic [15:0] rd;
      int lat, b_oe;
      exp_t e;
      inst = 1'b1;
      b_oe = oe_dq;
      sb.push_back('{is_rd: 1'b1, rdata: 16'hA55A, lat: 8});
      run_txn(1'b0, 14'h0005, 16'h0000, 2'b00, got, rd, lat);
      e = sb.pop_front();
      n_total++;
      if (got !== 1'b1) $display("FAIL readback_rsp: rsp seen=%b, want 1", got);
      else n_pass++;
      n_total++;
      if (rd !== e.rdata) $display("FAIL readback_data: got %h, want %h", rd, e.rdata);
      else n_pass++;
      n_total++;
      if (lat !== e.lat) $display("FAIL readback_lat: got %0d, want %0d", lat, e.lat);
      else n_pass++;
      n_total++;
      if (oe_dq - b_oe !== 0) $display("FAIL readback_dq_oe: cycles=%0d, want 0", oe_dq - b_oe);
      else n_pass++;
   endtask

   task automatic test_partial;
      logic got;
      logic [15:0] rd;
      int lat, b_ce;
      exp_t e;
      inst = 1'b1;
      sb.push_back('{is_rd: 1'b0, rdata: 16'h0, lat: 4});
      run_txn(1'b1, 14'h0005, 16'h1234, 2'b01, got, rd, lat);
      e = sb.pop_front();
      n_total++;
      if (got !== 1'b1 || lat !== e.lat)
         $display("FAIL partial_lat: seen=%b lat=%0d, want 1/%0d", got, lat, e.lat);
      else n_pass++;
      n_total++;
      if ({mem1[15'h000A], mem1[15'h000B]} !== 16'hA534)
         $display("FAIL partial_mem: got %h, want a534", {mem1[15'h000A], mem1[15'h000B]});
      else n_pass++;

      sb.push_back('{is_rd: 1'b1, rdata: 16'hA534, lat: 8});
      run_txn(1'b0, 14'h0005, 16'h0000, 2'b11, got, rd, lat);
      e = sb.pop_front();
      n_total++;
      if (got !== 1'b1 || rd !== e.rdata)
         $display("FAIL partial_readback: seen=%b data=%h, want 1/%h", got, rd, e.rdata);
      else n_pass++;
      n_total++;
      if (lat !== e.lat) $display("FAIL partial_readback_lat: got %0d, want %0d", lat, e.lat);
      else n_pass++;

      b_ce = ce_act;
      sb.push_back('{is_rd: 1'b0, rdata: 16'h0, lat: 1});
      run_txn(1'b1, 14'h0005, 16'hFFFF, 2'b00, got, rd, lat);
      e = sb.pop_front();
      n_total++;
      if (got !== 1'b1 || lat !== e.lat)
         $display("FAIL be00_lat: seen=%b lat=%0d, want 1/%0d", got, lat, e.lat);
      else n_pass++;
      n_total++;
      if (ce_act - b_ce !== 0) $display("FAIL be00_ce_activity: cycles=%0d, want 0", ce_act - b_ce);
      else n_pass++;
      n_total++;
      if ({mem1[15'h000A], mem1[15'h000B]} !== 16'hA534)
         $display("FAIL be00_mem: got %h, want a534", {mem1[15'h000A], mem1[15'h000B]});
      else n_pass++;
      n_total++;
      if (m_rdata !== 16'hA534) $display("FAIL be00_rdata_held: got %h, want a534", m_rdata);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int acc[2];
      int lats[2];
      logic [15:0] rds[2];
      int n_acc, n_rsp, b_inv, b_rdy;
      logic switched;
      exp_t e;
      inst = 1'b0;
      acc[0] = 0; acc[1] = 0; lats[0] = 0; lats[1] = 0; rds[0] = 16'h0; rds[1] = 16'h0;
      n_acc = 0; n_rsp = 0; switched = 1'b0;
      @(negedge clk);
      b_inv = bad_inv; b_rdy = rdy_bad;
      req_we = 1'b1; req_addr = 14'h3FFF; req_wdata = 16'hBEEF; req_be = 2'b11; req_valid = 1'b1;
      for (int i = 0; i < 60 && n_rsp < 2; i++) begin
         // Request fields change only once the controller has left IDLE.
         if (n_acc == 1 && !switched) begin
            req_we = 1'b0; req_wdata = 16'h0000; req_be = 2'b00; switched = 1'b1;
         end
         if (n_acc == 2) req_valid = 1'b0;
         if (m_rsp_valid && n_rsp < 2) begin
            rds[n_rsp]  = m_rdata;
            lats[n_rsp] = cyc - acc[n_rsp] + 1;
            n_rsp++;
         end
         if (m_ready && req_valid && n_acc < 2) begin
            acc[n_acc] = cyc + 1;
            if (n_acc == 0) sb.push_back('{is_rd: 1'b0, rdata: 16'h0, lat: 6});
            else            sb.push_back('{is_rd: 1'b1, rdata: 16'hBEEF, lat: 6});
            n_acc++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_total++;
      if (n_rsp !== 2) $display("FAIL b2b_rsp_count: got %0d, want 2", n_rsp);
      else n_pass++;
      for (int k = 0; k < n_rsp && sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_total++;
         if (lats[k] !== e.lat) $display("FAIL b2b_lat_%0d: got %0d, want %0d", k, lats[k], e.lat);
         else n_pass++;
         if (e.is_rd) begin
            n_total++;
            if (rds[k] !== e.rdata) $display("FAIL b2b_read_data: got %h, want %h", rds[k], e.rdata);
            else n_pass++;
         end
      end
      sb.delete();
      n_total++;
      if (acc[1] - acc[0] !== 7) $display("FAIL b2b_accept_gap: got %0d, want 7", acc[1] - acc[0]);
      else n_pass++;
      n_total++;
      if ({mem0[15'h7FFE], mem0[15'h7FFF]} !== 16'hBEEF)
         $display("FAIL b2b_mem: got %h, want beef", {mem0[15'h7FFE], mem0[15'h7FFF]});
      else n_pass++;
      n_total++;
      if (bad_inv - b_inv !== 0) $display("FAIL b2b_invariant: got %0d, want 0", bad_inv - b_inv);
      else n_pass++;
      n_total++;
      if (rdy_bad - b_rdy !== 0) $display("FAIL b2b_ready_busy: got %0d, want 0", rdy_bad - b_rdy);
      else n_pass++;
   endtask

   initial begin
      test_reset;
      test_word_write;
      test_readback;
      test_partial;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
